subbytes_engine: RTL and testbench
==================================

SUBBYTES_ENGINE -- requirements
Module: subbytes_engine

Interface
REQ-001 Parameter LANES, default 4, number of parallel S-box lanes; legal values 1, 2, 4, 8, 16.
REQ-002 Parameter INV_EN, default 1; 1 = inverse S-box datapath present, 0 = forward-only.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_state/in_inv valid this cycle.
REQ-006 in_ready  output  1  engine can accept a new state.
REQ-007 in_state  input  128  AES state; byte 0 = bits [127:120], byte 15 = bits [7:0].
REQ-008 in_inv  input  1  0 = SubBytes, 1 = InvSubBytes; sampled at acceptance.
REQ-009 out_valid  output  1  out_state holds a completed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_state  output  128  substituted state, same byte order as in_state.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1; on in_valid=1, latch in_state into the working register, latch in_inv into the mode flag, clear the step counter, go to RUN.
REQ-015 RUN: each cycle, replace bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register with their S-box (mode=0) or inverse S-box (mode=1) value; other bytes unchanged.
REQ-016 Step counter width = clog2(16/LANES), minimum 1 bit; increments once per RUN cycle; after the step with cnt = 16/LANES-1, go to DONE and clear cnt.
REQ-017 Latency: acceptance at edge k gives out_valid=1 after edge k+16/LANES; LANES=16 gives one RUN cycle.
REQ-018 DONE: out_valid=1; out_state = working register, held stable until taken; on out_ready=1, go to IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored there and no input is lost or overwritten.
REQ-020 out_valid SHALL be 0 in IDLE and RUN; out_ready is ignored there.
REQ-021 S-box and inverse S-box SHALL be the FIPS-197 tables, combinational, one instance per lane.
REQ-022 INV_EN=0: no inverse tables are instantiated; in_inv is ignored and forward substitution is always applied.
REQ-023 out_state SHALL reflect the working register in all states; it is defined only while out_valid=1.
REQ-024 Back-to-back operation: with in_valid held high, the next acceptance occurs the cycle after DONE->IDLE; throughput = one state per 16/LANES+2 cycles.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, cnt=0, mode=0, working register=0, in_ready=1, out_valid=0, busy=0, out_state=0.
REQ-026 Reset asserted in RUN or DONE SHALL discard the operation in progress; no out_valid follows the release of reset.
REQ-027 The first acceptance is possible on the first rising edge with rst_n=1.

Verification
REQ-028 LANES=4, forward, in_state all 0x00 -> out_valid 4 cycles after acceptance, out_state all 0x63.
REQ-029 Forward, bytes 00,23,56,A3,4E,19,FF,CC,DF,00.. -> bytes 63,26,B1,0A,2F,D4,16,4B,9E,63..; repeat for LANES=1, 2, 8, 16 with identical results and latencies 16, 8, 2, 1.
REQ-030 Forward FIPS-197 App. B: 19a09ae93df4c6f8e3e28d48be2b2a08 -> d4e0b81e27bfb44111985d52aef1e530; inverse of that result -> original input.
REQ-031 Inverse, all 0x16 -> all 0xFF; with INV_EN=0 and in_inv=1, all 0x00 -> all 0x63.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE -> out_state stable, in_ready=0, a second in_valid not accepted; out_ready=1 -> IDLE next cycle, then second state accepted.
REQ-033 rst_n pulsed low at RUN cycle 2 -> outputs at reset values immediately, no out_valid after release; a new input then completes normally.

Source files
------------

// File: rtl/subbytes_engine_if.sv
// Handshake bundle for subbytes_engine: state in, substituted state out.
interface subbytes_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/subbytes_engine.sv
// AES SubBytes / InvSubBytes engine: substitutes one 128-bit state, LANES bytes per cycle.
module subbytes_engine #(
    parameter int LANES  = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    subbytes_engine_if.slave sb
);
    localparam int            STEPS    = 16 / LANES;
    localparam int            CW       = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    // Element 0 is the most significant byte, so SBOX[x] is the table entry for x.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic [127:0]  work_q, work_d;
    logic          in_ready, out_valid, busy;
    logic [7:0]    lane_in  [LANES];
    logic [7:0]    lane_out [LANES];

    // Lane gi always works on byte cnt*LANES+gi of the working register.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_in[gi] = work_q[127 - 8*(int'(cnt_q)*LANES + gi) -: 8];
        if (INV_EN) begin : g_inv
            assign lane_out[gi] = mode_q ? INV_SBOX[lane_in[gi]] : SBOX[lane_in[gi]];
        end else begin : g_fwd
            assign lane_out[gi] = SBOX[lane_in[gi]];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        work_d    = work_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (sb.in_valid) begin
                    work_d  = sb.in_state;
                    mode_d  = INV_EN && sb.in_inv;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    work_d[127 - 8*(int'(cnt_q)*LANES + l) -: 8] = lane_out[l];
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (sb.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
        end
    end

    assign sb.in_ready  = in_ready;
    assign sb.out_valid = out_valid;
    assign sb.busy      = busy;
    assign sb.out_state = work_q;
endmodule

// File: tb/tb_subbytes_engine.sv
// Bench for subbytes_engine: six instances (LANES 4,1,2,8,16 and forward-only) share stimulus.
module tb_subbytes_engine;
    localparam int NI = 6;
    localparam int LANES_T [NI] = '{4, 1, 2, 8, 16, 4};
    localparam bit INV_T   [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_inv, out_ready;
    logic [127:0]  in_state;
    logic [NI-1:0] en_mask;
    logic [NI-1:0] in_ready_a, out_valid_a, busy_a;
    logic [127:0]  out_state_a [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        subbytes_engine_if ifc ();
        assign ifc.in_valid    = in_valid & en_mask[gi];
        assign ifc.in_state    = in_state;
        assign ifc.in_inv      = in_inv;
        assign ifc.out_ready   = out_ready;
        assign in_ready_a[gi]  = ifc.in_ready;
        assign out_valid_a[gi] = ifc.out_valid;
        assign busy_a[gi]      = ifc.busy;
        assign out_state_a[gi] = ifc.out_state;
        subbytes_engine #(.LANES(LANES_T[gi]), .INV_EN(INV_T[gi])) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .sb    (ifc)
        );
    end

    int           checks = 0;
    int           passes = 0;
    int           cyc = 0;
    int           acc_cyc [NI];
    int           acc_cnt [NI];
    bit           lat_pend [NI];
    logic [127:0] exp_q [NI][$];
    logic [7:0]   fwd_tbl [256];
    logic [7:0]   inv_tbl [256];

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
        logic [127:0] exp_noinv;
    } vec_t;
    vec_t vecs [6];

    // Arithmetic reference: GF(2^8) inverse followed by the AES affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] r = b ^ 8'h63;
        for (int k = 1; k <= 4; k++) r = r ^ ((b << k) | (b >> (8 - k)));
        return r;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) begin
            r[127 - 8*b -: 8] = inv ? inv_tbl[s[127 - 8*b -: 8]] : fwd_tbl[s[127 - 8*b -: 8]];
        end
        return r;
    endfunction

    task automatic chk(input string name, input int inst, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s inst=%0d lanes=%0d got=%0h want=%0h", name, inst, LANES_T[inst], act, exp);
    endtask

    // One clock: handshakes are judged just before the edge, latency just after.
    task automatic tick();
        logic [127:0] e;
        for (int i = 0; i < NI; i++) begin
            if (rst_n && in_valid && en_mask[i] && in_ready_a[i]) begin
                acc_cyc[i]  = cyc + 1;
                acc_cnt[i]  = acc_cnt[i] + 1;
                lat_pend[i] = 1'b1;
            end
            if (rst_n && out_valid_a[i] && out_ready) begin
                if (exp_q[i].size() == 0) begin
                    chk("unexpected_output", i, out_state_a[i], 128'hx);
                end else begin
                    e = exp_q[i].pop_front();
                    $display("txn inst=%0d lanes=%0d inv_en=%0d out=%h", i, LANES_T[i], INV_T[i], out_state_a[i]);
                    chk("out_state", i, out_state_a[i], e);
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (lat_pend[i] && out_valid_a[i]) begin
                chk("latency", i, 128'(cyc - acc_cyc[i]), 128'(16 / LANES_T[i]));
                lat_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [NI-1:0] mask, input logic [127:0] s, input logic inv,
                        input logic [127:0] e1, input logic [127:0] e0);
        int n = 0;
        while (((in_ready_a & mask) != mask) && n < 200) begin
            tick();
            n++;
        end
        en_mask  = mask;
        in_valid = 1'b1;
        in_state = s;
        in_inv   = inv;
        for (int i = 0; i < NI; i++) if (mask[i]) exp_q[i].push_back(INV_T[i] ? e1 : e0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < NI; i++) if (mask[i]) chk("accepted", i, 128'(busy_a[i]), 128'd1);
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NI; i++) if (exp_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain();
        int n = 0;
        while (pending() && n < 300) begin
            tick();
            n++;
        end
        for (int i = 0; i < NI; i++) begin
            if (exp_q[i].size() != 0) begin
                checks++;
                $display("FAIL drain_timeout inst=%0d got=%0d pending want=0", i, exp_q[i].size());
                exp_q[i].delete();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] s, va, vb, vk, vr;
        logic         r_inv;
        logic [7:0]   p;
        int           n, start, prev;
        bit           any_ov;

        rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_inv = 1'b0; out_ready = 1'b1; en_mask = '1;
        for (int i = 0; i < NI; i++) begin
            acc_cyc[i] = 0; acc_cnt[i] = 0; lat_pend[i] = 1'b0;
        end
        for (int x = 0; x < 256; x++) begin
            p = 8'h01;
            for (int k = 0; k < 254; k++) p = gmul(p, 8'(x));
            fwd_tbl[x] = affine(p);
        end
        for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = 8'(x);

        vecs[0] = '{128'h0, 1'b0, {16{8'h63}}, {16{8'h63}}};
        vecs[1] = '{128'h002356a34e19ffccdf00000000000000, 1'b0,
                    128'h6326b10a2fd4164b9e63636363636363, 128'h6326b10a2fd4164b9e63636363636363};
        vecs[2] = '{128'h19a09ae93df4c6f8e3e28d48be2b2a08, 1'b0,
                    128'hd4e0b81e27bfb44111985d52aef1e530, 128'hd4e0b81e27bfb44111985d52aef1e530};
        vecs[3] = '{128'hd4e0b81e27bfb44111985d52aef1e530, 1'b1,
                    128'h19a09ae93df4c6f8e3e28d48be2b2a08, 128'h48e16c72cc088d8382464c00e4a1d904};
        vecs[4] = '{{16{8'h16}}, 1'b1, {16{8'hff}}, {16{8'h47}}};
        vecs[5] = '{128'h0, 1'b1, {16{8'h52}}, {16{8'h63}}};

        @(negedge clk);
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            chk("rst_in_ready", i, 128'(in_ready_a[i]), 128'd1);
            chk("rst_out_valid", i, 128'(out_valid_a[i]), 128'd0);
            chk("rst_busy", i, 128'(busy_a[i]), 128'd0);
            chk("rst_out_state", i, out_state_a[i], 128'd0);
        end
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            send('1, vecs[v].din, vecs[v].inv, vecs[v].exp, vecs[v].exp_noinv);
            drain();
        end

        for (int t = 0; t < 8; t++) begin
            s     = {$urandom(), $urandom(), $urandom(), $urandom()};
            r_inv = 1'($urandom_range(0, 1));
            send('1, s, r_inv, model(s, r_inv), model(s, 1'b0));
            drain();
        end

        // Backpressure on the LANES=4 instance with a second request waiting.
        va = 128'h00112233445566778899aabbccddeeff;
        vb = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        out_ready = 1'b0; en_mask = NI'(1); in_inv = 1'b0; in_state = va; in_valid = 1'b1;
        exp_q[0].push_back(model(va, 1'b0));
        tick();
        in_state = vb;
        n = 0;
        while (!out_valid_a[0] && n < 40) begin
            tick();
            n++;
        end
        chk("bp_done_reached", 0, 128'(out_valid_a[0]), 128'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_state_held", 0, out_state_a[0], model(va, 1'b0));
            chk("bp_in_ready_low", 0, 128'(in_ready_a[0]), 128'd0);
            chk("bp_out_valid_held", 0, 128'(out_valid_a[0]), 128'd1);
        end
        out_ready = 1'b1;
        exp_q[0].push_back(model(vb, 1'b0));
        tick();
        chk("bp_idle_in_ready", 0, 128'(in_ready_a[0]), 128'd1);
        chk("bp_idle_out_valid", 0, 128'(out_valid_a[0]), 128'd0);
        tick();
        chk("bp_second_accepted", 0, 128'(busy_a[0]), 128'd1);
        in_valid = 1'b0;
        drain();

        // Back-to-back with in_valid held high: one acceptance every 16/LANES+2 cycles.
        en_mask = NI'(1); in_inv = 1'b1; in_valid = 1'b1; prev = 0;
        for (int k = 0; k < 3; k++) begin
            vk = {4{$urandom()}};
            in_state = vk;
            exp_q[0].push_back(model(vk, 1'b1));
            start = acc_cnt[0];
            n = 0;
            while (acc_cnt[0] == start && n < 40) begin
                tick();
                n++;
            end
            if (k > 0) chk("b2b_interval", 0, 128'(acc_cyc[0] - prev), 128'd6);
            prev = acc_cyc[0];
        end
        in_valid = 1'b0;
        drain();

        // Reset pulse during the second RUN cycle discards the operation.
        vr = 128'hdeadbeef0123456789abcdeffedcba98;
        send(NI'(1), vr, 1'b0, model(vr, 1'b0), model(vr, 1'b0));
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 0, 128'(in_ready_a[0]), 128'd1);
        chk("mid_rst_busy", 0, 128'(busy_a[0]), 128'd0);
        chk("mid_rst_out_valid", 0, 128'(out_valid_a[0]), 128'd0);
        chk("mid_rst_out_state", 0, out_state_a[0], 128'd0);
        exp_q[0].delete();
        lat_pend[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        any_ov = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid_a[0]) any_ov = 1'b1;
        end
        chk("post_rst_no_valid", 0, 128'(any_ov), 128'd0);
        send(NI'(1), vr, 1'b1, model(vr, 1'b1), model(vr, 1'b0));
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
